// File: rtl/config_uart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// config_uart_loader : framed UART packet receiver feeding config words
// Rev 1.0
// =====================================================================
module config_uart_loader #(
  parameter int          CLK_DIV        = 174,
  parameter int          WORD_BYTES     = 4,
  parameter int          MODE           = 0,
  parameter int          TIMEOUT_CYCLES = 16776,
  parameter logic [23:0] PKT_ID         = 24'h00AAFF
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic                    Rx,
  output logic [8*WORD_BYTES-1:0] WriteData,
  output logic                    WriteStrobe,
  output logic                    ComActive,
  output logic [7:0]              Command,
  output logic [15:0]             ByteCount,
  output logic                    Done,
  output logic                    ChecksumOk,
  output logic [2:0]              ErrFlags
);
  localparam int WW = 8 * WORD_BYTES;
  localparam int TW = $clog2(CLK_DIV);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {RX_IDLE, START, BITS, STOP} bitState_t;
  typedef enum logic [3:0] {IDLE, ID0, ID1, ID2, CMD, LEN_H, LEN_L, DATA, SUM_H, SUM_L} pktState_t;

  logic [1:0] rstSync;
  logic       rstnInt;

  // Reset asserts asynchronously and releases two clocks later.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) rstSync <= 2'b00;
    else         rstSync <= {rstSync[0], 1'b1};
  end
  assign rstnInt = rstSync[1];

  bitState_t       bitState;
  logic            rxMeta, rxs;
  logic [TW-1:0]   bitTimer;
  logic [2:0]      bitCnt;
  logic [7:0]      shiftReg, rxByte;
  logic            byteValid, frameErr;

  always_ff @(posedge CLK or negedge rstnInt) begin
    if (!rstnInt) begin
      rxMeta    <= 1'b1;
      rxs       <= 1'b1;
      bitState  <= RX_IDLE;
      bitTimer  <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxMeta    <= Rx;
      rxs       <= rxMeta;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      case (bitState)
        RX_IDLE: if (!rxs) begin
          bitState <= START;
          bitTimer <= TW'(CLK_DIV / 2 - 1);
        end
        START: if (bitTimer != '0) bitTimer <= bitTimer - 1'b1;
          else if (rxs) bitState <= RX_IDLE;
          else begin
            bitState <= BITS;
            bitTimer <= TW'(CLK_DIV - 1);
            bitCnt   <= '0;
          end
        BITS: if (bitTimer != '0) bitTimer <= bitTimer - 1'b1;
          else begin
            shiftReg <= {rxs, shiftReg[7:1]};
            bitTimer <= TW'(CLK_DIV - 1);
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) bitState <= STOP;
          end
        STOP: if (bitTimer != '0) bitTimer <= bitTimer - 1'b1;
          else begin
            if (rxs) begin
              byteValid <= 1'b1;
              rxByte    <= shiftReg;
            end else begin
              frameErr  <= 1'b1;
            end
            bitState <= RX_IDLE;
          end
        default: bitState <= RX_IDLE;
      endcase
    end
  end

  pktState_t     pktState;
  logic          hexMode, nibPhase;
  logic [3:0]    hiNib, hexNib;
  logic          hexOk;
  logic [15:0]   pktLen, checksum;
  logic [7:0]    sumHi, payByte;
  logic [IW-1:0] byteIdx;
  logic [WW-1:0] asmWord, newWord;
  logic [OW-1:0] toCnt;
  logic          toReload, toExpire, lastByte, wordFull;

  always_comb begin
    hexNib = '0;
    hexOk  = 1'b1;
    if (rxByte >= 8'h30 && rxByte <= 8'h39)
      hexNib = rxByte[3:0];
    else if ((rxByte >= 8'h41 && rxByte <= 8'h46) || (rxByte >= 8'h61 && rxByte <= 8'h66))
      hexNib = rxByte[3:0] + 4'd9;
    else
      hexOk = 1'b0;
  end

  assign payByte  = hexMode ? {hiNib, hexNib} : rxByte;
  assign lastByte = (ByteCount + 16'd1 == pktLen);
  assign wordFull = (byteIdx == IW'(WORD_BYTES - 1));

  // Bytes land MSB-first; the first byte of a word starts from a zero word.
  always_comb begin
    newWord = (byteIdx == '0) ? '0 : asmWord;
    for (int i = 0; i < WORD_BYTES; i++)
      if (byteIdx == IW'(i)) newWord[8*(WORD_BYTES-1-i) +: 8] = payByte;
  end

  assign toReload = (pktState == IDLE) || (bitState != RX_IDLE) || byteValid;
  assign toExpire = !toReload && (toCnt == '0);

  always_ff @(posedge CLK or negedge rstnInt) begin
    if (!rstnInt) begin
      pktState    <= IDLE;
      WriteData   <= '0;
      WriteStrobe <= 1'b0;
      ComActive   <= 1'b0;
      Command     <= '0;
      ByteCount   <= '0;
      Done        <= 1'b0;
      ChecksumOk  <= 1'b0;
      ErrFlags    <= '0;
      hexMode     <= 1'b0;
      nibPhase    <= 1'b0;
      hiNib       <= '0;
      pktLen      <= '0;
      checksum    <= '0;
      sumHi       <= '0;
      byteIdx     <= '0;
      asmWord     <= '0;
      toCnt       <= '0;
    end else begin
      WriteStrobe <= 1'b0;
      Done        <= 1'b0;
      if (toReload)         toCnt <= OW'(TIMEOUT_CYCLES);
      else if (toCnt != '0) toCnt <= toCnt - 1'b1;

      if (pktState == IDLE) begin
        // The falling edge that launches a byte also opens a new packet.
        if (bitState == RX_IDLE && !rxs) begin
          pktState   <= ID0;
          ErrFlags   <= '0;
          ChecksumOk <= 1'b0;
          ByteCount  <= '0;
          checksum   <= '0;
          byteIdx    <= '0;
          nibPhase   <= 1'b0;
        end
      end else if (frameErr) begin
        ErrFlags[1] <= 1'b1;
        pktState    <= IDLE;
        ComActive   <= 1'b0;
      end else if (toExpire) begin
        ErrFlags[2] <= 1'b1;
        pktState    <= IDLE;
        ComActive   <= 1'b0;
      end else if (byteValid) begin
        case (pktState)
          ID0: pktState <= (rxByte == PKT_ID[23:16]) ? ID1 : IDLE;
          ID1: pktState <= (rxByte == PKT_ID[15:8])  ? ID2 : IDLE;
          ID2: pktState <= (rxByte == PKT_ID[7:0])   ? CMD : IDLE;
          CMD: if (rxByte[6:0] == 7'd1 || rxByte[6:0] == 7'd2) begin
            Command  <= rxByte;
            hexMode  <= (MODE == 1) ? 1'b1 : (MODE == 2) ? 1'b0 : rxByte[7];
            pktState <= LEN_H;
          end else begin
            pktState <= IDLE;
          end
          LEN_H: begin
            pktLen[15:8] <= rxByte;
            pktState     <= LEN_L;
          end
          LEN_L: begin
            pktLen[7:0] <= rxByte;
            if ({pktLen[15:8], rxByte} == 16'd0) pktState <= SUM_H;
            else begin
              pktState  <= DATA;
              ComActive <= 1'b1;
            end
          end
          DATA: begin
            if (hexMode && !hexOk) begin
              ErrFlags[0] <= 1'b1;
            end else if (hexMode && !nibPhase) begin
              hiNib    <= hexNib;
              nibPhase <= 1'b1;
            end else begin
              nibPhase  <= 1'b0;
              checksum  <= checksum + {8'h00, payByte};
              ByteCount <= ByteCount + 16'd1;
              if (wordFull || lastByte) begin
                WriteData   <= newWord;
                WriteStrobe <= 1'b1;
                byteIdx     <= '0;
              end else begin
                asmWord <= newWord;
                byteIdx <= byteIdx + 1'b1;
              end
              if (lastByte) begin
                pktState  <= SUM_H;
                ComActive <= 1'b0;
              end
            end
          end
          SUM_H: begin
            sumHi    <= rxByte;
            pktState <= SUM_L;
          end
          SUM_L: begin
            ChecksumOk <= ({sumHi, rxByte} == checksum);
            Done       <= 1'b1;
            pktState   <= IDLE;
          end
          default: pktState <= IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_config_uart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// tb_config_uart_loader : directed packets, scoreboard-checked outputs
// Rev 1.0
// =====================================================================
module tb_config_uart_loader;
  localparam int CLK_DIV = 8;
  localparam int TOUT    = 200;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic resetn = 1'b0;
  logic rxA = 1'b1, rxB = 1'b1;

  logic [31:0] wdA;  logic wsA, caA, doneA, okA;  logic [7:0] cmdA;  logic [15:0] bcA;  logic [2:0] errA;
  logic [15:0] wdB;  logic wsB, caB, doneB, okB;  logic [7:0] cmdB;  logic [15:0] bcB;  logic [2:0] errB;

  config_uart_loader #(.CLK_DIV(CLK_DIV), .WORD_BYTES(4), .MODE(0), .TIMEOUT_CYCLES(TOUT), .PKT_ID(24'h00AAFF)) dutA (
    .CLK(CLK), .resetn(resetn), .Rx(rxA), .WriteData(wdA), .WriteStrobe(wsA), .ComActive(caA),
    .Command(cmdA), .ByteCount(bcA), .Done(doneA), .ChecksumOk(okA), .ErrFlags(errA));

  config_uart_loader #(.CLK_DIV(CLK_DIV), .WORD_BYTES(2), .MODE(0), .TIMEOUT_CYCLES(TOUT), .PKT_ID(24'h00AAFF)) dutB (
    .CLK(CLK), .resetn(resetn), .Rx(rxB), .WriteData(wdB), .WriteStrobe(wsB), .ComActive(caB),
    .Command(cmdB), .ByteCount(bcB), .Done(doneB), .ChecksumOk(okB), .ErrFlags(errB));

  typedef struct packed { logic isDone; logic [31:0] data; logic ok; logic [2:0] err; } ev_t;
  ev_t qA[$], qB[$];
  logic [7:0] txq[$];
  int nChecks = 0, nFail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mkWord(input logic [31:0] d);
    return '{isDone: 1'b0, data: d, ok: 1'b0, err: 3'b000};
  endfunction
  function automatic ev_t mkDone(input logic ok, input logic [2:0] err);
    return '{isDone: 1'b1, data: 32'h0, ok: ok, err: err};
  endfunction

  // Scoreboard monitors: every strobe or Done must match the head of the queue.
  always @(negedge CLK) begin : monA
    ev_t e;
    if (resetn && (wsA || doneA)) begin
      if (qA.size() == 0) begin
        nChecks++; nFail++;
        $display("FAIL A_unexpected_event: strobe=%b done=%b data=%h, expected none", wsA, doneA, wdA);
      end else begin
        e = qA.pop_front();
        check("A_event_is_done", 64'(doneA), 64'(e.isDone));
        if (wsA) check("A_WriteData", 64'(wdA), 64'(e.data));
        else begin
          check("A_ChecksumOk", 64'(okA), 64'(e.ok));
          check("A_ErrFlags_at_Done", 64'(errA), 64'(e.err));
        end
      end
    end
  end

  always @(negedge CLK) begin : monB
    ev_t e;
    if (resetn && (wsB || doneB)) begin
      if (qB.size() == 0) begin
        nChecks++; nFail++;
        $display("FAIL B_unexpected_event: strobe=%b done=%b data=%h, expected none", wsB, doneB, wdB);
      end else begin
        e = qB.pop_front();
        check("B_event_is_done", 64'(doneB), 64'(e.isDone));
        if (wsB) check("B_WriteData", 64'(wdB), 64'(e.data));
        else begin
          check("B_ChecksumOk", 64'(okB), 64'(e.ok));
          check("B_ErrFlags_at_Done", 64'(errB), 64'(e.err));
        end
      end
    end
  end

  task automatic setRx(input bit toB, input logic v);
    if (toB) rxB = v; else rxA = v;
  endtask

  // One 8N1 frame; a bad stop bit is held low just past the sampling point.
  task automatic sendByte(input bit toB, input logic [7:0] b, input bit badStop);
    setRx(toB, 1'b0);
    repeat (CLK_DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      setRx(toB, b[i]);
      repeat (CLK_DIV) @(negedge CLK);
    end
    if (badStop) begin
      setRx(toB, 1'b0);
      repeat (CLK_DIV / 2 + 1) @(negedge CLK);
    end
    setRx(toB, 1'b1);
    repeat (CLK_DIV) @(negedge CLK);
  endtask

  task automatic sendQ(input bit toB);
    logic [7:0] b;
    while (txq.size() > 0) begin
      b = txq.pop_front();
      sendByte(toB, b, 1'b0);
    end
  endtask

  task automatic pushHdr(input logic [7:0] cmd, input logic [15:0] len);
    txq.push_back(8'h00); txq.push_back(8'hAA); txq.push_back(8'hFF);
    txq.push_back(cmd); txq.push_back(len[15:8]); txq.push_back(len[7:0]);
  endtask

  task automatic pushRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) txq.push_back(8'(i));
  endtask

  task automatic goodPacketA(input logic [7:0] sumLo, input logic expOk);
    qA.push_back(mkWord(32'h01020304));
    qA.push_back(mkWord(32'h05060708));
    qA.push_back(mkDone(expOk, 3'b000));
    pushHdr(8'h01, 16'd8); pushRange(1, 8);
    txq.push_back(8'h00); txq.push_back(sumLo);
    sendQ(1'b0);
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("A_reset_WriteData", 64'(wdA), 64'd0);
    check("A_reset_WriteStrobe", 64'(wsA), 64'd0);
    check("A_reset_ComActive", 64'(caA), 64'd0);
    check("A_reset_Command", 64'(cmdA), 64'd0);
    check("A_reset_ByteCount", 64'(bcA), 64'd0);
    check("A_reset_Done", 64'(doneA), 64'd0);
    check("A_reset_ChecksumOk", 64'(okA), 64'd0);
    check("A_reset_ErrFlags", 64'(errA), 64'd0);
    check("B_reset_WriteData", 64'(wdB), 64'd0);
    resetn = 1'b1;
    repeat (5) @(negedge CLK);

    // Binary packet, 8 bytes into two 32-bit words, with a mid-packet look.
    qA.push_back(mkWord(32'h01020304));
    qA.push_back(mkWord(32'h05060708));
    qA.push_back(mkDone(1'b1, 3'b000));
    pushHdr(8'h01, 16'd8); pushRange(1, 3);
    sendQ(1'b0);
    check("A_ComActive_in_data", 64'(caA), 64'd1);
    check("A_ByteCount_mid", 64'(bcA), 64'd3);
    pushRange(4, 8); txq.push_back(8'h00); txq.push_back(8'h24);
    sendQ(1'b0);
    repeat (10) @(negedge CLK);
    check("A_ByteCount_end", 64'(bcA), 64'd8);
    check("A_Command", 64'(cmdA), 64'h01);
    check("A_ComActive_after", 64'(caA), 64'd0);
    check("A_ChecksumOk_sticky", 64'(okA), 64'd1);

    // Hex payload into 16-bit words; 'z' flags bad_hex; A1+B2+C3 = 0x0216.
    qB.push_back(mkWord(32'h0000A1B2));
    qB.push_back(mkWord(32'h0000C300));
    qB.push_back(mkDone(1'b1, 3'b001));
    pushHdr(8'h81, 16'd3);
    txq.push_back("a"); txq.push_back("1"); txq.push_back("B"); txq.push_back("2");
    txq.push_back("z"); txq.push_back("C"); txq.push_back("3");
    txq.push_back(8'h02); txq.push_back(8'h16);
    sendQ(1'b1);
    repeat (10) @(negedge CLK);
    check("B_Command_hex", 64'(cmdB), 64'h81);
    check("B_ByteCount_hex", 64'(bcB), 64'd3);
    check("B_ErrFlags_hex", 64'(errB), 64'b001);

    // Wrong trailer: words still written, verdict false.
    goodPacketA(8'h25, 1'b0);
    check("A_ChecksumOk_bad", 64'(okA), 64'd0);

    // Two-cycle low glitch is rejected, then a normal packet decodes.
    rxA = 1'b0;
    repeat (2) @(negedge CLK);
    rxA = 1'b1;
    repeat (20) @(negedge CLK);
    goodPacketA(8'h24, 1'b1);
    check("A_ErrFlags_after_glitch", 64'(errA), 64'd0);

    // Zero-length packet goes straight to the trailer.
    qB.push_back(mkDone(1'b1, 3'b000));
    pushHdr(8'h02, 16'd0); txq.push_back(8'h00); txq.push_back(8'h00);
    sendQ(1'b1);
    repeat (10) @(negedge CLK);
    check("B_ByteCount_len0", 64'(bcB), 64'd0);

    // Framing error on the sixth payload byte drops the partial word.
    qA.push_back(mkWord(32'h01020304));
    pushHdr(8'h01, 16'd8); pushRange(1, 5);
    sendQ(1'b0);
    sendByte(1'b0, 8'h06, 1'b1);
    repeat (20) @(negedge CLK);
    check("A_ErrFlags_framing", 64'(errA), 64'b010);
    check("A_ComActive_framing", 64'(caA), 64'd0);
    check("A_ByteCount_framing", 64'(bcA), 64'd5);

    // Stall after five payload bytes until the inter-byte timeout fires.
    qA.push_back(mkWord(32'h01020304));
    pushHdr(8'h01, 16'd8); pushRange(1, 5);
    sendQ(1'b0);
    repeat (TOUT + 10) @(negedge CLK);
    check("A_ErrFlags_timeout", 64'(errA), 64'b100);
    check("A_ComActive_timeout", 64'(caA), 64'd0);

    // Reset in the middle of a start bit clears everything at once.
    rxA = 1'b0;
    repeat (12) @(negedge CLK);
    resetn = 1'b0;
    #1;
    check("A_rst_mid_WriteData", 64'(wdA), 64'd0);
    check("A_rst_mid_Command", 64'(cmdA), 64'd0);
    check("A_rst_mid_ByteCount", 64'(bcA), 64'd0);
    check("A_rst_mid_ComActive", 64'(caA), 64'd0);
    check("A_rst_mid_Strobe_Done", 64'({wsA, doneA, okA}), 64'd0);
    check("A_rst_mid_ErrFlags", 64'(errA), 64'd0);
    check("B_rst_mid_Command", 64'(cmdB), 64'd0);
    rxA = 1'b1;
    repeat (4) @(negedge CLK);
    resetn = 1'b1;
    repeat (40) @(negedge CLK);

    check("A_pending_events", 64'(qA.size()), 64'd0);
    check("B_pending_events", 64'(qB.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
`default_nettype wire
